// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard controller for a 5-stage F-D-E-M-WB pipeline.
// Tracks destination-register records for the EX, MEM and WB stages, detects
// load-use hazards, and produces registered EX-operand forwarding selects.
// Optional feature macro: HAZ_WB_BYPASS_EN (decode-time WB bypass for rs1/rs2).
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_stall,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rf_we,
  input  logic              id_is_load,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  slot_t            ex_q, mem_q, wb_q, ex_d;
  logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  // A slot produces register r only if it is a real, writing instruction; x0 never matches.
  function automatic logic writes(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.we && (s.rd == r) && (r != '0);
  endfunction

  // Youngest producer wins: a non-load in EX beats anything in MEM.
  function automatic logic [1:0] fwd_sel(input logic rd_used, input logic [REG_AW-1:0] r,
                                         input slot_t ex_s, input slot_t mem_s);
    if (!rd_used)            return SEL_RF;
    else if (writes(ex_s, r))  return SEL_MEM;
    else if (writes(mem_s, r)) return SEL_WB;
    else                       return SEL_RF;
  endfunction

  // Hazard detection and next-state for the EX slot, forwarding selects and counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ex_d    = '{valid: id_valid, rd: id_rd, we: id_rf_we, load: id_is_load};
    fwd_a_d = fwd_sel(id_valid && id_use_rs1, id_rs1, ex_q, mem_q);
    fwd_b_d = fwd_sel(id_valid && id_use_rs2, id_rs2, ex_q, mem_q);
    cnt_d   = cnt_q;

    lu = id_valid && ex_q.load &&
         ((id_use_rs1 && writes(ex_q, id_rs1)) || (id_use_rs2 && writes(ex_q, id_rs2)));

    if (lu) begin
      ex_d    = '0;
      fwd_a_d = SEL_RF;
      fwd_b_d = SEL_RF;
    end

    if (flush_e && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Stall/flush are same-cycle outputs; reset forces them low.
  assign stall_f = ~rst & (ext_stall | lu);
  assign stall_d = stall_f;
  assign flush_e = ~rst & lu & ~ext_stall;

  // Shadow pipeline, forwarding registers and stall counter; ext_stall freezes everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else if (!ext_stall) begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = cnt_q;

`ifdef HAZ_WB_BYPASS_EN
  // Decode reads the WB result directly when the WB slot produces the source register.
  assign id_byp_a = ~rst & id_valid & id_use_rs1 & writes(wb_q, id_rs1);
  assign id_byp_b = ~rst & id_valid & id_use_rs2 & writes(wb_q, id_rs2);
`else
  // The register file is write-first, so no decode-time bypass is needed.
  assign id_byp_a = 1'b0;
  assign id_byp_b = 1'b0;
`endif

  // The WB slot's load bit (and, without bypass, the whole slot) is kept for visibility only.
  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule
